// File: rtl/operand_collector.sv
// Collects a burst of WIDTH-bit values into DEPTH ordered slots and publishes
// them as one registered snapshot (valid bits, count, overflow) when the burst ends.
module operand_collector #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 3,
    parameter int OVF_MODE = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     put,
    input  logic [WIDTH-1:0]         value,
    output logic                     ready,
    output logic                     ack,
    output logic                     busy,
    output logic                     pub_valid,
    output logic [DEPTH*WIDTH-1:0]   slots_out,
    output logic [DEPTH-1:0]         slot_valid,
    output logic [CW-1:0]            pub_count,
    output logic                     overflow
);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          count_reg, count_next;
    logic                   ovf_reg, ovf_next;
    logic [WIDTH-1:0]       slot_reg [DEPTH];
    logic                   store, publish;
    logic [CW-1:0]          wr_idx;
    logic [DEPTH-1:0]       slot_we;
    logic [DEPTH-1:0]       therm;
    logic [DEPTH*WIDTH-1:0] slot_flat;

    logic                   ack_reg, pub_valid_reg, overflow_reg;
    logic [DEPTH*WIDTH-1:0] slots_out_reg;
    logic [DEPTH-1:0]       slot_valid_reg;
    logic [CW-1:0]          pub_count_reg;

    wire full = (count_reg == CW'(DEPTH));

    // Once full, overwrites (OVF_MODE=1) always land in the last slot.
    assign wr_idx = full ? CW'(DEPTH - 1) : count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign slot_we[gi]                     = store && (wr_idx == CW'(gi));
            assign therm[gi]                       = (count_reg > CW'(gi));
            assign slot_flat[gi*WIDTH +: WIDTH]    = slot_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        ovf_next   = ovf_reg;
        store      = 1'b0;
        publish    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (put) begin
                    store      = 1'b1;
                    count_next = CW'(1);
                    state_next = FILL;
                end
            end
            FILL: begin
                if (put) begin
                    if (!full) begin
                        store      = 1'b1;
                        count_next = count_reg + CW'(1);
                    end else begin
                        ovf_next = 1'b1;
                        store    = (OVF_MODE != 0);
                    end
                end else begin
                    publish    = 1'b1;
                    count_next = '0;
                    ovf_next   = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Slots are zeroed on publish so unfilled slots of the next burst read 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (publish)         slot_reg[i] <= '0;
                else if (slot_we[i]) slot_reg[i] <= value;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_reg        <= 1'b0;
            pub_valid_reg  <= 1'b0;
            slots_out_reg  <= '0;
            slot_valid_reg <= '0;
            pub_count_reg  <= '0;
            overflow_reg   <= 1'b0;
        end else begin
            ack_reg       <= store;
            pub_valid_reg <= publish;
            if (publish) begin
                slots_out_reg  <= slot_flat;
                slot_valid_reg <= therm;
                pub_count_reg  <= count_reg;
                overflow_reg   <= ovf_reg;
            end
        end
    end

    assign ready      = !full;
    assign busy       = (state_reg == FILL);
    assign ack        = ack_reg;
    assign pub_valid  = pub_valid_reg;
    assign slots_out  = slots_out_reg;
    assign slot_valid = slot_valid_reg;
    assign pub_count  = pub_count_reg;
    assign overflow   = overflow_reg;

endmodule
